// File: rtl/lsnn_step_scheduler_if.sv
// Host-side bundle of the LSNN step scheduler: current writes, step control,
// spike/step reporting and debug read-back.
interface lsnn_step_scheduler_if #(
    parameter int N    = 4,
    parameter int IDXW = $clog2(N)
);
    logic            in_valid;
    logic            in_ready;
    logic [IDXW-1:0] in_idx;
    logic [7:0]      in_current;
    logic            step_start;
    logic            busy;
    logic            step_done;
    logic [N-1:0]    spike_out;
    logic [15:0]     step_count;
    logic [IDXW-1:0] dbg_idx;
    logic [7:0]      dbg_state;
    logic [7:0]      dbg_threshold;

    modport master (
        output in_valid, in_idx, in_current, step_start, dbg_idx,
        input  in_ready, busy, step_done, spike_out, step_count, dbg_state, dbg_threshold
    );

    modport slave (
        input  in_valid, in_idx, in_current, step_start, dbg_idx,
        output in_ready, busy, step_done, spike_out, step_count, dbg_state, dbg_threshold
    );
endinterface

// File: rtl/lsnn_step_scheduler.sv
// Sequencer sharing one adaptive-threshold neuron update across N virtual
// neurons: buffers host currents, sweeps all neurons per step, reports spikes.
//
//   state  | meaning
//   S_IDLE | accepting current writes; step_start launches a sweep
//   S_PROC | updating neuron idx_q, one neuron per cycle
//   S_DONE | one-cycle step_done pulse, spike_out/step_count just updated
module lsnn_step_scheduler #(
    parameter int N     = 4,
    parameter int ALPHA = 8,
    parameter int B0J   = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    lsnn_step_scheduler_if.slave bus
);
    localparam int IDXW = $clog2(N);

    typedef enum logic [1:0] {S_IDLE, S_PROC, S_DONE} fsm_t;

    fsm_t            fsm_q, fsm_d;
    logic [IDXW-1:0] idx_q;
    logic [7:0]      state_q [N];
    logic [7:0]      adapt_q [N];
    logic [7:0]      cur_q   [N];
    logic [N-1:0]    spike_next_q;
    logic [N-1:0]    spike_q;
    logic [15:0]     count_q;

    logic            wr_en;
    logic            last;
    logic [7:0]      sel_state, sel_adapt, sel_cur;
    logic [7:0]      thr;
    logic            spk;
    logic [7:0]      new_state, new_adapt;
    logic [N-1:0]    spike_vec;

    function automatic logic [7:0] sat8(input logic [8:0] v);
        return v[8] ? 8'hFF : v[7:0];
    endfunction

    // ---------------- FSM ----------------
    always_ff @(posedge clk) begin
        if (rst_n) fsm_q <= S_IDLE;
        else       fsm_q <= fsm_d;
    end

    assign last = (idx_q == IDXW'(N - 1));

    always_comb begin
        fsm_d = fsm_q;
        unique case (fsm_q)
            S_IDLE: if (bus.step_start) fsm_d = S_PROC;
            S_PROC: if (last) fsm_d = S_DONE;
            S_DONE: fsm_d = S_IDLE;
            default: fsm_d = S_IDLE;
        endcase
    end

    assign bus.in_ready  = (fsm_q == S_IDLE);
    assign bus.busy      = (fsm_q != S_IDLE);
    assign bus.step_done = (fsm_q == S_DONE);
    assign wr_en         = bus.in_valid && bus.in_ready;

    // ---------------- neuron datapath ----------------
    assign sel_state = state_q[idx_q];
    assign sel_adapt = adapt_q[idx_q];
    assign sel_cur   = cur_q[idx_q];
    assign thr       = sat8(9'(sel_adapt) + 9'(B0J));
    assign spk       = (sel_state >= thr);
    assign new_state = sat8(9'(sel_cur) + 9'(sel_state >> 1));
    // Decay branch tops out at 127+63, so it never needs clamping.
    assign new_adapt = spk ? sat8(9'(sel_adapt) + 9'(sel_adapt >> 2))
                           : (sel_adapt >> 1) + (sel_adapt >> 2);

    always_comb begin
        spike_vec        = spike_next_q;
        spike_vec[idx_q] = spk;
    end

    // ---------------- contexts ----------------
    always_ff @(posedge clk) begin
        for (int i = 0; i < N; i++) begin
            if (rst_n) begin
                state_q[i] <= 8'd0;
                adapt_q[i] <= 8'(ALPHA);
                cur_q[i]   <= 8'd0;
            end else if (wr_en && bus.in_idx == IDXW'(i)) begin
                cur_q[i] <= sat8(9'(cur_q[i]) + 9'(bus.in_current));
            end else if (fsm_q == S_PROC && idx_q == IDXW'(i)) begin
                state_q[i] <= new_state;
                adapt_q[i] <= new_adapt;
                cur_q[i]   <= 8'd0;
            end
        end
    end

    // ---------------- sweep index and step results ----------------
    always_ff @(posedge clk) begin
        if (rst_n) begin
            idx_q        <= '0;
            spike_next_q <= '0;
            spike_q      <= '0;
            count_q      <= 16'd0;
        end else begin
            if (fsm_q == S_IDLE && bus.step_start) idx_q <= '0;
            if (fsm_q == S_PROC) begin
                idx_q        <= idx_q + 1'b1;
                spike_next_q <= spike_vec;
                if (last) begin
                    spike_q <= spike_vec;
                    count_q <= count_q + 16'd1;
                end
            end
        end
    end

    assign bus.spike_out     = spike_q;
    assign bus.step_count    = count_q;
    assign bus.dbg_state     = state_q[bus.dbg_idx];
    assign bus.dbg_threshold = sat8(9'(adapt_q[bus.dbg_idx]) + 9'(B0J));
endmodule

// File: tb/tb_lsnn_step_scheduler.sv
// Directed bench for lsnn_step_scheduler with hand-computed expectations.
module tb_lsnn_step_scheduler;
    localparam int N = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    int   vectors = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    lsnn_step_scheduler_if #(.N(N)) ifc ();

    lsnn_step_scheduler #(.N(N), .ALPHA(8), .B0J(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifc.slave)
    );

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b1;
        ifc.in_valid = 1'b0;
        ifc.step_start = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
    endtask

    task automatic write_cur(input int idx, input int val);
        @(negedge clk);
        ifc.in_valid   = 1'b1;
        ifc.in_idx     = 2'(idx);
        ifc.in_current = 8'(val);
        @(negedge clk);
        ifc.in_valid   = 1'b0;
    endtask

    // Returns at the negedge inside the DONE cycle.
    task automatic run_step();
        int c;
        @(negedge clk);
        ifc.step_start = 1'b1;
        @(negedge clk);
        ifc.step_start = 1'b0;
        for (c = 0; c < 20 && !ifc.step_done; c++) @(negedge clk);
        if (!ifc.step_done) begin
            miscompares++;
            $display("FAIL step_timeout: step_done=%0b after %0d cycles, required 1", ifc.step_done, c);
        end
    endtask

    task automatic dbg_read(input int idx, output logic [7:0] st, output logic [7:0] th);
        ifc.dbg_idx = 2'(idx);
        #1;
        st = ifc.dbg_state;
        th = ifc.dbg_threshold;
    endtask

    task automatic test_reset();
        logic [7:0] st, th;
        do_reset();
        @(negedge clk);
        for (int i = 0; i < N; i++) begin
            dbg_read(i, st, th);
            vectors++;
            if (st !== 8'd0) begin miscompares++; $display("FAIL reset_state[%0d]: got %0d want 0", i, st); end
            vectors++;
            if (th !== 8'd16) begin miscompares++; $display("FAIL reset_thr[%0d]: got %0d want 16", i, th); end
        end
        vectors++;
        if (ifc.spike_out !== 4'b0 || ifc.step_count !== 16'd0) begin
            miscompares++;
            $display("FAIL reset_outputs: spike=%b count=%0d want 0/0", ifc.spike_out, ifc.step_count);
        end
        vectors++;
        if (ifc.in_ready !== 1'b1 || ifc.busy !== 1'b0 || ifc.step_done !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_handshake: ready=%b busy=%b done=%b want 1/0/0", ifc.in_ready, ifc.busy, ifc.step_done);
        end
    endtask

    task automatic test_basic();
        logic [7:0] st, th;
        logic exp_done;
        do_reset();
        write_cur(0, 20);
        @(negedge clk);
        ifc.step_start = 1'b1;
        for (int c = 1; c <= N + 2; c++) begin
            @(negedge clk);
            ifc.step_start = 1'b0;
            exp_done = (c == N + 1);
            vectors++;
            if (ifc.step_done !== exp_done) begin
                miscompares++;
                $display("FAIL latency_c%0d: step_done=%b want %b", c, ifc.step_done, exp_done);
            end
            if (c == N + 1) begin
                vectors++;
                if (ifc.spike_out[0] !== 1'b0 || ifc.step_count !== 16'd1) begin
                    miscompares++;
                    $display("FAIL step1_out: spike0=%b count=%0d want 0/1", ifc.spike_out[0], ifc.step_count);
                end
            end
        end
        dbg_read(0, st, th);
        vectors++;
        if (st !== 8'd20 || th !== 8'd14) begin miscompares++; $display("FAIL step1_n0: state=%0d thr=%0d want 20/14", st, th); end

        run_step();
        dbg_read(0, st, th);
        vectors++;
        if (ifc.spike_out[0] !== 1'b1 || st !== 8'd10 || th !== 8'd15) begin
            miscompares++;
            $display("FAIL step2_n0: spike=%b state=%0d thr=%0d want 1/10/15", ifc.spike_out[0], st, th);
        end

        run_step();
        dbg_read(0, st, th);
        vectors++;
        if (ifc.spike_out[0] !== 1'b0 || st !== 8'd5 || th !== 8'd12 || ifc.step_count !== 16'd3) begin
            miscompares++;
            $display("FAIL step3_n0: spike=%b state=%0d thr=%0d count=%0d want 0/5/12/3", ifc.spike_out[0], st, th, ifc.step_count);
        end
    endtask

    task automatic test_current_sat();
        logic [7:0] st, th;
        do_reset();
        write_cur(1, 200);
        write_cur(1, 100);
        run_step();
        dbg_read(1, st, th);
        vectors++;
        if (st !== 8'd255 || ifc.spike_out !== 4'b0000) begin
            miscompares++;
            $display("FAIL cur_sat_step1: state=%0d spike=%b want 255/0000", st, ifc.spike_out);
        end
        run_step();
        dbg_read(1, st, th);
        vectors++;
        if (st !== 8'd127 || ifc.spike_out !== 4'b0010) begin
            miscompares++;
            $display("FAIL cur_sat_step2: state=%0d spike=%b want 127/0010", st, ifc.spike_out);
        end
    endtask

    task automatic test_adapt_sat();
        logic [7:0] st, th;
        do_reset();
        for (int s = 1; s <= 23; s++) begin
            write_cur(2, 255);
            run_step();
            dbg_read(2, st, th);
            if (s == 19) begin
                vectors++;
                if (th !== 8'd243) begin miscompares++; $display("FAIL adapt_step19: thr=%0d want 243", th); end
            end
            if (s >= 20) begin
                vectors++;
                if (th !== 8'd255 || ifc.spike_out[2] !== 1'b1) begin
                    miscompares++;
                    $display("FAIL adapt_sat_s%0d: thr=%0d spike=%b want 255/1", s, th, ifc.spike_out[2]);
                end
            end
        end
    endtask

    task automatic test_handshake();
        logic [7:0] st, th;
        int saw_done = 0;
        do_reset();
        @(negedge clk);
        ifc.in_valid = 1'b1; ifc.in_idx = 2'd3; ifc.in_current = 8'd50; ifc.step_start = 1'b1;
        @(negedge clk);
        vectors++;
        if (ifc.in_ready !== 1'b0 || ifc.busy !== 1'b1) begin
            miscompares++;
            $display("FAIL hs_proc: ready=%b busy=%b want 0/1", ifc.in_ready, ifc.busy);
        end
        ifc.in_idx = 2'd0; ifc.in_current = 8'd30;
        @(negedge clk);
        ifc.step_start = 1'b1;
        @(negedge clk);
        ifc.step_start = 1'b0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (ifc.step_done) saw_done++;
            if (ifc.in_ready) break;
        end
        @(negedge clk);
        ifc.in_valid = 1'b0;
        dbg_read(3, st, th);
        vectors++;
        if (saw_done !== 1 || ifc.step_count !== 16'd1 || st !== 8'd50) begin
            miscompares++;
            $display("FAIL hs_step1: done_pulses=%0d count=%0d state3=%0d want 1/1/50", saw_done, ifc.step_count, st);
        end
        run_step();
        dbg_read(0, st, th);
        vectors++;
        if (st !== 8'd30) begin miscompares++; $display("FAIL hs_held_write: state0=%0d want 30", st); end
        dbg_read(3, st, th);
        vectors++;
        if (st !== 8'd25 || ifc.spike_out !== 4'b1000 || ifc.step_count !== 16'd2) begin
            miscompares++;
            $display("FAIL hs_step2: state3=%0d spike=%b count=%0d want 25/1000/2", st, ifc.spike_out, ifc.step_count);
        end
    endtask

    task automatic test_mid_reset();
        logic [7:0] st, th;
        int done_seen = 0;
        do_reset();
        write_cur(0, 20);
        run_step();
        write_cur(1, 40);
        @(negedge clk);
        ifc.step_start = 1'b1;
        @(negedge clk);
        ifc.step_start = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        rst_n = 1'b0;
        if (ifc.step_done) done_seen++;
        vectors++;
        if (ifc.busy !== 1'b0 || ifc.in_ready !== 1'b1 || ifc.step_count !== 16'd0 || ifc.spike_out !== 4'b0) begin
            miscompares++;
            $display("FAIL midrst_outputs: busy=%b ready=%b count=%0d spike=%b want 0/1/0/0000", ifc.busy, ifc.in_ready, ifc.step_count, ifc.spike_out);
        end
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (ifc.step_done) done_seen++;
        end
        vectors++;
        if (done_seen !== 0) begin miscompares++; $display("FAIL midrst_done: pulses=%0d want 0", done_seen); end
        for (int i = 0; i < N; i++) begin
            dbg_read(i, st, th);
            vectors++;
            if (st !== 8'd0 || th !== 8'd16) begin
                miscompares++;
                $display("FAIL midrst_ctx[%0d]: state=%0d thr=%0d want 0/16", i, st, th);
            end
        end
        // Pending current for n1 must be gone too.
        run_step();
        dbg_read(1, st, th);
        vectors++;
        if (st !== 8'd0 || ifc.step_count !== 16'd1) begin
            miscompares++;
            $display("FAIL midrst_cur: state1=%0d count=%0d want 0/1", st, ifc.step_count);
        end
    endtask

    initial begin
        ifc.in_valid = 1'b0;
        ifc.in_idx = '0;
        ifc.in_current = '0;
        ifc.step_start = 1'b0;
        ifc.dbg_idx = '0;
        test_reset();
        test_basic();
        test_current_sat();
        test_adapt_sat();
        test_handshake();
        test_mid_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
